// File: rtl/dds_multi_channel_gen_if.sv
// Channel-addressed configuration bus and per-channel sample outputs for dds_multi_channel_gen.
interface dds_multi_channel_gen_if #(
    parameter int CH_NUM = 2,
    parameter int DATA_W = 14
);
    logic                       i_cfg_vld;
    logic [2:0]                 i_cfg_ch;
    logic [2:0]                 i_cfg_addr;
    logic [31:0]                i_cfg_data;
    logic                       i_commit;
    logic                       i_sync;
    logic [CH_NUM-1:0]          o_dds_vld;
    logic [CH_NUM*DATA_W-1:0]   o_dds_data;

    modport master (
        output i_cfg_vld, i_cfg_ch, i_cfg_addr, i_cfg_data, i_commit, i_sync,
        input  o_dds_vld, o_dds_data
    );

    modport slave (
        input  i_cfg_vld, i_cfg_ch, i_cfg_addr, i_cfg_data, i_commit, i_sync,
        output o_dds_vld, o_dds_data
    );
endinterface

// File: rtl/dds_multi_channel_gen.sv
// Multi-channel DDS: per-channel accumulator, waveform, gain, offset and saturation with shadow/active config.
// Optional frequency sweep (registers 6/7) is built only when DDS_SWEEP_EN is defined.
module dds_multi_channel_gen #(
    parameter int CH_NUM = 2,
    parameter int ACC_W  = 32,
    parameter int PW_W   = 12,
    parameter int DATA_W = 14,
    parameter int AMP_W  = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    dds_multi_channel_gen_if.slave bus
);
    localparam logic [2:0] MODE_SAW   = 3'd1;
    localparam logic [2:0] MODE_TRI   = 3'd2;
    localparam logic [2:0] MODE_PULSE = 3'd3;
    localparam logic [2:0] MODE_DC    = 3'd4;

    localparam int SW = DATA_W + 2;
    localparam int PW = DATA_W + AMP_W + 1;

    localparam logic signed [DATA_W-1:0] POS_FS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] NEG_FS = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]        MID    = {1'b1, {(DATA_W-1){1'b0}}};

    genvar k;
    generate
        for (k = 0; k < CH_NUM; k++) begin : g_ch
            logic                     wr_en;
            logic                     sh_run, act_run;
            logic [2:0]               sh_mode, act_mode;
            logic [ACC_W-1:0]         sh_fword, act_fword, cur_fword;
            logic [PW_W-1:0]          sh_pword, act_pword;
            logic [9:0]               sh_duty, act_duty;
            logic [AMP_W-1:0]         sh_amp, act_amp;
            logic signed [DATA_W-1:0] sh_offset, act_offset;
            logic [ACC_W-1:0]         acc;

            logic [DATA_W:0]          ph_top;
            logic [DATA_W-1:0]        t, u, v;
            logic signed [DATA_W-1:0] raw_c;
            logic                     vld_c;

            logic signed [DATA_W-1:0] raw_q, off_q1, off_q2;
            logic [AMP_W-1:0]         amp_q;
            logic signed [PW-1:0]     prod;
            logic signed [SW-1:0]     scaled_c, scaled_q;
            logic signed [SW:0]       sum_c;
            logic signed [DATA_W-1:0] sat_c;
            logic [DATA_W-1:0]        lane_c, lane_q;
            logic                     vld_q1, vld_q2, vld_q3;

            assign wr_en = bus.i_cfg_vld && (bus.i_cfg_ch == 3'(k));

            // Commit copies the pre-write shadow: a same-cycle write lands in shadow only.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    sh_run     <= 1'b0;  act_run    <= 1'b0;
                    sh_mode    <= '0;    act_mode   <= '0;
                    sh_fword   <= '0;    act_fword  <= '0;
                    sh_pword   <= '0;    act_pword  <= '0;
                    sh_duty    <= '0;    act_duty   <= '0;
                    sh_amp     <= '0;    act_amp    <= '0;
                    sh_offset  <= '0;    act_offset <= '0;
                end else begin
                    if (bus.i_commit) begin
                        act_run    <= sh_run;
                        act_mode   <= sh_mode;
                        act_fword  <= sh_fword;
                        act_pword  <= sh_pword;
                        act_duty   <= sh_duty;
                        act_amp    <= sh_amp;
                        act_offset <= sh_offset;
                    end
                    if (wr_en) begin
                        case (bus.i_cfg_addr)
                            3'd0: begin
                                sh_run  <= bus.i_cfg_data[3];
                                sh_mode <= bus.i_cfg_data[2:0];
                            end
                            3'd1:    sh_fword  <= bus.i_cfg_data[ACC_W-1:0];
                            3'd2:    sh_pword  <= bus.i_cfg_data[PW_W-1:0];
                            3'd3:    sh_duty   <= bus.i_cfg_data[9:0];
                            3'd4:    sh_amp    <= bus.i_cfg_data[AMP_W-1:0];
                            3'd5:    sh_offset <= bus.i_cfg_data[DATA_W-1:0];
                            default: ;
                        endcase
                    end
                end
            end

`ifdef DDS_SWEEP_EN
            logic [ACC_W-1:0] sh_step, act_step, sh_stop, act_stop;
            logic [ACC_W:0]   fw_next;

            assign fw_next = {1'b0, cur_fword} + {1'b0, act_step};

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    sh_step  <= '0;  act_step <= '0;
                    sh_stop  <= '0;  act_stop <= '0;
                end else begin
                    if (bus.i_commit) begin
                        act_step <= sh_step;
                        act_stop <= sh_stop;
                    end
                    if (wr_en && bus.i_cfg_addr == 3'd6) sh_step <= bus.i_cfg_data[ACC_W-1:0];
                    if (wr_en && bus.i_cfg_addr == 3'd7) sh_stop <= bus.i_cfg_data[ACC_W-1:0];
                end
            end

            // The live sweep word restarts from the committed start fword on commit, sync or overrun.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    cur_fword <= '0;
                end else if (bus.i_commit) begin
                    cur_fword <= sh_fword;
                end else if (bus.i_sync) begin
                    cur_fword <= act_fword;
                end else if (act_run && act_step != '0) begin
                    cur_fword <= (fw_next > {1'b0, act_stop}) ? act_fword : fw_next[ACC_W-1:0];
                end
            end
`else
            assign cur_fword = act_fword;
`endif

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    acc <= '0;
                end else if (bus.i_sync) begin
                    acc <= '0;
                end else if (act_run) begin
                    acc <= acc + cur_fword;
                end
            end

            // Only the top DATA_W+1 phase bits feed the waveform; the shift keeps the whole sum in use.
            assign ph_top = (DATA_W+1)'((acc + {act_pword, {(ACC_W-PW_W){1'b0}}}) >> (ACC_W-DATA_W-1));
            assign t      = ph_top[DATA_W:1];
            assign u      = ph_top[DATA_W-1:0];
            assign v      = ph_top[DATA_W] ? ~u : u;

            always_comb begin
                raw_c = '0;
                if (act_run) begin
                    case (act_mode)
                        MODE_SAW:   raw_c = {~t[DATA_W-1], t[DATA_W-2:0]};
                        MODE_TRI:   raw_c = {~v[DATA_W-1], v[DATA_W-2:0]};
                        MODE_PULSE: raw_c = (ph_top[DATA_W -: 10] < act_duty) ? POS_FS : NEG_FS;
                        default:    raw_c = '0;
                    endcase
                end
            end

            assign vld_c = act_run && (act_mode != 3'd0) && (act_mode <= MODE_DC);

            assign prod     = PW'(raw_q) * PW'($signed({1'b0, amp_q}));
            assign scaled_c = SW'(prod >>> (AMP_W-1));
            assign sum_c    = (SW+1)'(scaled_q) + (SW+1)'(off_q2);

            always_comb begin
                sat_c = DATA_W'(sum_c);
                if (sum_c > (SW+1)'(POS_FS)) begin
                    sat_c = POS_FS;
                end else if (sum_c < (SW+1)'(NEG_FS)) begin
                    sat_c = NEG_FS;
                end
            end

            assign lane_c = {~sat_c[DATA_W-1], sat_c[DATA_W-2:0]};

            // Gain, offset and run travel with their sample so config changes stay 3-clock aligned.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    raw_q    <= '0;
                    amp_q    <= '0;
                    off_q1   <= '0;
                    vld_q1   <= 1'b0;
                    scaled_q <= '0;
                    off_q2   <= '0;
                    vld_q2   <= 1'b0;
                    lane_q   <= MID;
                    vld_q3   <= 1'b0;
                end else begin
                    raw_q    <= raw_c;
                    amp_q    <= act_amp;
                    off_q1   <= act_offset;
                    vld_q1   <= vld_c;
                    scaled_q <= scaled_c;
                    off_q2   <= off_q1;
                    vld_q2   <= vld_q1;
                    lane_q   <= lane_c;
                    vld_q3   <= vld_q2;
                end
            end

            assign bus.o_dds_data[k*DATA_W +: DATA_W] = lane_q;
            assign bus.o_dds_vld[k]                   = vld_q3;
        end
    endgenerate
endmodule
